ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter that splits 32-bit word requests into four byte accesses on one 8-bit registered RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority with m0 winning ties.
module ram_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   input  logic              m0_rready,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   input  logic              m1_rready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              grant,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

   state_t state_q, state_n;

   logic              we_q, we_n;
   logic [RAM_AW-1:0] base_q, base_n;
   logic [31:0]       wdata_q, wdata_n;
   logic [3:0]        wstrb_q, wstrb_n;
   logic [2:0]        cnt_q, cnt_n;
   logic [23:0]       rbuf_q, rbuf_n;

   logic              m0_ready_n, m1_ready_n, m0_rvalid_n, m1_rvalid_n;
   logic [31:0]       m0_rdata_n, m1_rdata_n;
   logic              ram_en_n, ram_we_n;
   logic [RAM_AW-1:0] ram_addr_n;
   logic [7:0]        ram_wdata_n;
   logic              grant_n, busy_n;

   logic              win;
   logic [ADDR_W-1:0] addr_sel;
   logic [31:0]       rdata_done;

   // Requester address bits [1:0] and those above the RAM width never reach the RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr, m1_addr};

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // Remembers the last winner; reset to 1 so m0 takes the first contested round.
   logic rr_last_q, rr_last_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_last_q <= 1'b1;
      else     rr_last_q <= rr_last_n;
   end

   always_comb begin
      if (m0_valid && m1_valid) win = ~rr_last_q;
      else                      win = m1_valid;
      rr_last_n = rr_last_q;
      if (state_q == IDLE && (m0_valid || m1_valid)) rr_last_n = win;
   end
`else
   always_comb begin
      win = ~m0_valid;
   end
`endif

   assign addr_sel = win ? m1_addr : m0_addr;

   // Every output is a flop; this block only computes their next values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         base_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         cnt_q     <= '0;
         rbuf_q    <= '0;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         grant     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_n;
         we_q      <= we_n;
         base_q    <= base_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         cnt_q     <= cnt_n;
         rbuf_q    <= rbuf_n;
         m0_ready  <= m0_ready_n;
         m1_ready  <= m1_ready_n;
         m0_rvalid <= m0_rvalid_n;
         m1_rvalid <= m1_rvalid_n;
         m0_rdata  <= m0_rdata_n;
         m1_rdata  <= m1_rdata_n;
         ram_en    <= ram_en_n;
         ram_we    <= ram_we_n;
         ram_addr  <= ram_addr_n;
         ram_wdata <= ram_wdata_n;
         grant     <= grant_n;
         busy      <= busy_n;
      end
   end

   assign rdata_done = we_q ? 32'h0 : {ram_rdata, rbuf_q};

   // cnt_q counts edges since grant: 0..3 drive byte cnt_q, and byte cnt_q-2 arrives from the RAM.
   always_comb begin
      state_n     = state_q;
      we_n        = we_q;
      base_n      = base_q;
      wdata_n     = wdata_q;
      wstrb_n     = wstrb_q;
      cnt_n       = cnt_q;
      rbuf_n      = rbuf_q;
      m0_ready_n  = 1'b0;
      m1_ready_n  = 1'b0;
      m0_rvalid_n = m0_rvalid;
      m1_rvalid_n = m1_rvalid;
      m0_rdata_n  = m0_rdata;
      m1_rdata_n  = m1_rdata;
      ram_en_n    = 1'b0;
      ram_we_n    = 1'b0;
      ram_addr_n  = ram_addr;
      ram_wdata_n = 8'h00;
      grant_n     = grant;

      if (state_q == XFER || state_q == DRAIN) begin
         case (cnt_q)
            3'd2:    rbuf_n[7:0]   = ram_rdata;
            3'd3:    rbuf_n[15:8]  = ram_rdata;
            3'd4:    rbuf_n[23:16] = ram_rdata;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               grant_n    = win;
               m0_ready_n = ~win;
               m1_ready_n = win;
               we_n       = win ? m1_we : m0_we;
               wdata_n    = win ? m1_wdata : m0_wdata;
               wstrb_n    = win ? m1_wstrb : m0_wstrb;
               base_n     = {addr_sel[RAM_AW-1:2], 2'b00};
               cnt_n      = 3'd0;
               state_n    = XFER;
            end
         end
         XFER: begin
            ram_en_n    = 1'b1;
            ram_addr_n  = base_q + RAM_AW'(cnt_q[1:0]);
            ram_we_n    = we_q & wstrb_q[cnt_q[1:0]];
            ram_wdata_n = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_n       = cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
               if (we_q) begin
                  state_n = RESP;
                  if (grant) begin m1_rvalid_n = 1'b1; m1_rdata_n = 32'h0; end
                  else       begin m0_rvalid_n = 1'b1; m0_rdata_n = 32'h0; end
               end else begin
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            cnt_n = cnt_q + 3'd1;
            if (cnt_q == 3'd5) begin
               state_n = RESP;
               if (grant) begin m1_rvalid_n = 1'b1; m1_rdata_n = rdata_done; end
               else       begin m0_rvalid_n = 1'b1; m0_rdata_n = rdata_done; end
            end
         end
         RESP: begin
            if (grant ? m1_rready : m0_rready) begin
               m0_rvalid_n = 1'b0;
               m1_rvalid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural 1-cycle-latency byte RAM.
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_valid = 0, m0_we = 0, m0_rready = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0;
   logic [3:0]  m0_wstrb = 0;
   logic        m1_valid = 0, m1_we = 0, m1_rready = 0;
   logic [31:0] m1_addr = 0, m1_wdata = 0;
   logic [3:0]  m1_wstrb = 0;
   logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en, ram_we, grant, busy;
   logic [18:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;

   logic [7:0]  mem [0:(1<<19)-1];

   int checks = 0;
   int failures = 0;

   ram_port_arbiter #(.ADDR_W(32), .RAM_AW(19)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m0_rready(m0_rready),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .m1_rready(m1_rready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   // Registered read-first byte RAM.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] memWord(input logic [18:0] a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   // One full transaction from request to completion handshake, with timing checks along the way.
   task automatic applyStimulus(input logic who, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] expRdata, input int holdCycles,
                                input logic raiseOther, input string tag);
      int lat, enCnt, weCnt;
      logic otherSeen, holdBad;
      logic [18:0] base;
      lat = we ? 4 : 6;
      base = {addr[18:2], 2'b00};
      enCnt = 0; weCnt = 0; otherSeen = 0; holdBad = 0;
      if (!who) begin
         m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1;
      end else begin
         m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1;
      end
      tick();
      checkOutput({tag, ".ready"}, who ? m1_ready : m0_ready, 1);
      checkOutput({tag, ".grant"}, grant, who);
      checkOutput({tag, ".busy"}, busy, 1);
      if (!who) m0_valid = 0; else m1_valid = 0;
      if (raiseOther) begin
         if (!who) begin m1_we = 0; m1_addr = 32'h104; m1_valid = 1; end
         else      begin m0_we = 0; m0_addr = 32'h104; m0_valid = 1; end
      end
      for (int i = 1; i <= lat; i++) begin
         tick();
         enCnt += ram_en; weCnt += ram_we;
         if (who ? (m0_ready | m0_rvalid) : (m1_ready | m1_rvalid)) otherSeen = 1;
         if (i == 1) begin
            checkOutput({tag, ".addr0"}, ram_addr, base);
            checkOutput({tag, ".we0"}, ram_we, we & wstrb[0]);
            if (we) checkOutput({tag, ".wdata0"}, ram_wdata, wdata[7:0]);
         end
         if (i == lat - 1) checkOutput({tag, ".early_rvalid"}, who ? m1_rvalid : m0_rvalid, 0);
      end
      checkOutput({tag, ".rvalid"}, who ? m1_rvalid : m0_rvalid, 1);
      checkOutput({tag, ".rdata"}, who ? m1_rdata : m0_rdata, expRdata);
      for (int i = 0; i < holdCycles; i++) begin
         tick();
         enCnt += ram_en; weCnt += ram_we;
         if (who ? (m0_ready | m0_rvalid) : (m1_ready | m1_rvalid)) otherSeen = 1;
         if ((who ? m1_rvalid : m0_rvalid) !== 1'b1 || (who ? m1_rdata : m0_rdata) !== expRdata ||
             busy !== 1'b1 || grant !== who) holdBad = 1;
      end
      if (holdCycles > 0) checkOutput({tag, ".hold_stable"}, holdBad, 0);
      if (!who) m0_rready = 1; else m1_rready = 1;
      tick();
      enCnt += ram_en;
      if (who ? (m0_ready | m0_rvalid) : (m1_ready | m1_rvalid)) otherSeen = 1;
      if (!who) m0_rready = 0; else m1_rready = 0;
      if (raiseOther) begin m0_valid = 0; m1_valid = 0; end
      checkOutput({tag, ".rvalid_clr"}, who ? m1_rvalid : m0_rvalid, 0);
      checkOutput({tag, ".idle"}, busy, 0);
      checkOutput({tag, ".en_cycles"}, enCnt, 4);
      checkOutput({tag, ".we_cycles"}, weCnt, we ? $countones(wstrb) : 0);
      checkOutput({tag, ".other_quiet"}, otherSeen, 0);
   endtask

   initial begin
      int grants [4];
      int waitCnt;
      logic sawRvalid;
      for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;

      // Reset state, with m0 already requesting so the first post-reset edge arbitrates.
      m0_we = 1; m0_addr = 32'h104; m0_wdata = 32'hA1B2C3D4; m0_wstrb = 4'hF; m0_valid = 1;
      repeat (3) @(negedge clk);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.grant", grant, 0);
      checkOutput("rst.ram_en", ram_en, 0);
      checkOutput("rst.m0_ready", m0_ready, 0);
      rst = 0;
      m0_valid = 0;
      applyStimulus(0, 1, 32'h104, 32'hA1B2C3D4, 4'hF, 32'h0, 0, 0, "wr104");
      checkOutput("wr104.mem", memWord(19'h104), 32'hA1B2C3D4);

      // m1 read, completion held for 10 cycles while m0 waits.
      applyStimulus(1, 0, 32'h104, 32'h0, 4'h0, 32'hA1B2C3D4, 10, 1, "rd104_hold");

      // Upper address bits ignored.
      applyStimulus(0, 0, 32'hFFF80104, 32'h0, 4'h0, 32'hA1B2C3D4, 0, 0, "rd_hiaddr");

      // Partial strobes over an all-ones word, then an empty-strobe write.
      applyStimulus(0, 1, 32'h200, 32'hFFFFFFFF, 4'hF, 32'h0, 0, 0, "wr200_ff");
      applyStimulus(0, 1, 32'h202, 32'h11223344, 4'h5, 32'h0, 0, 0, "wr200_strb5");
      applyStimulus(1, 0, 32'h200, 32'h0, 4'h0, 32'hFF22FF44, 0, 0, "rd200");
      applyStimulus(1, 1, 32'h200, 32'h55667788, 4'h0, 32'h0, 2, 0, "wr200_strb0");
      checkOutput("wr200_strb0.mem", memWord(19'h200), 32'hFF22FF44);

      // Reset two edges into a write abandons it; byte 0 already landed.
      m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF; m0_valid = 1;
      tick();
      m0_valid = 0;
      tick();
      tick();
      rst = 1;
      #1;
      checkOutput("midrst.ram_en", ram_en, 0);
      checkOutput("midrst.busy", busy, 0);
      @(negedge clk);
      rst = 0;
      sawRvalid = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (m0_rvalid | m1_rvalid | busy) sawRvalid = 1;
      end
      checkOutput("midrst.no_completion", sawRvalid, 0);
      checkOutput("midrst.byte0", mem[19'h300], 8'hEF);
      checkOutput("midrst.byte1", mem[19'h301], 8'h00);
      applyStimulus(1, 0, 32'h104, 32'h0, 4'h0, 32'hA1B2C3D4, 0, 0, "after_rst");

      // Contention from a fresh reset: both valid, both ready to accept completions.
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      m0_we = 0; m0_addr = 32'h104; m1_we = 0; m1_addr = 32'h200;
      m0_rready = 1; m1_rready = 1;
      m0_valid = 1; m1_valid = 1;
      for (int t = 0; t < 4; t++) begin
         waitCnt = 0;
         do begin
            tick();
            waitCnt++;
         end while (!(m0_ready | m1_ready) && waitCnt < 20);
         grants[t] = (m0_ready | m1_ready) ? int'(m1_ready) : -1;
         if (t == 3) begin m0_valid = 0; m1_valid = 0; end
      end
`ifdef RAM_ARB_ROUND_ROBIN_EN
      checkOutput("contend.g0", grants[0], 0);
      checkOutput("contend.g1", grants[1], 1);
      checkOutput("contend.g2", grants[2], 0);
      checkOutput("contend.g3", grants[3], 1);
`else
      checkOutput("contend.g0", grants[0], 0);
      checkOutput("contend.g1", grants[1], 0);
      checkOutput("contend.g2", grants[2], 0);
      checkOutput("contend.g3", grants[3], 0);
`endif
      waitCnt = 0;
      while (busy && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      checkOutput("contend.drain_idle", busy, 0);
      m0_rready = 0; m1_rready = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
